// File: rtl/exc_vector_ctrl.sv
// exc_vector_ctrl: exception/irq vectoring FSM; table index 1 cycle after the event, redirect 2 cycles after (irq +2 with EXC_IRQ_SYNC_EN).
// Backpressure: o_redirect/o_redirect_pc held until i_redirect_ack; events while busy are dropped (irqs are levels, so they re-present).
module exc_vector_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int VEC_ADDR_WIDTH = 4,
  parameter int IRQ_LINES      = 7
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [IRQ_LINES-1:0]      i_irq,
  input  logic                      i_exc_valid,
  input  logic [2:0]                i_exc_code,
  input  logic [DATA_WIDTH-1:0]     i_epc,
  input  logic                      i_eret,
  input  logic                      i_redirect_ack,
  output logic [VEC_ADDR_WIDTH-1:0] o_vec_idx,
  input  logic [DATA_WIDTH-1:0]     i_vec_data,
  output logic                      o_redirect,
  output logic [DATA_WIDTH-1:0]     o_redirect_pc,
  output logic [DATA_WIDTH-1:0]     o_epc,
  output logic [VEC_ADDR_WIDTH-1:0] o_cause,
  output logic                      o_in_handler
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_REDIRECT = 3'd2,
    S_HANDLER  = 3'd3,
    S_RETURN   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [VEC_ADDR_WIDTH-1:0] vec_idx_q, vec_idx_d;
  logic [VEC_ADDR_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0]     epc_q, epc_d;
  logic [DATA_WIDTH-1:0]     redirect_pc_q, redirect_pc_d;
  logic                      redirect_q, redirect_d;
  logic                      in_handler_q, in_handler_d;

  logic [IRQ_LINES-1:0]      irq_s;
  logic                      irq_any;
  logic [VEC_ADDR_WIDTH-1:0] irq_idx;

`ifdef EXC_IRQ_SYNC_EN
  logic [IRQ_LINES-1:0] irq_meta_q, irq_sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_meta_q <= '0;
      irq_sync_q <= '0;
    end else begin
      irq_meta_q <= i_irq;
      irq_sync_q <= irq_meta_q;
    end
  end

  assign irq_s = irq_sync_q;
`else
  assign irq_s = i_irq;
`endif

  // Scan from the top so the lowest asserted line is the one left standing.
  always_comb begin
    irq_any = 1'b0;
    irq_idx = '0;
    for (int n = IRQ_LINES - 1; n >= 0; n--) begin
      if (irq_s[n]) begin
        irq_any = 1'b1;
        irq_idx = VEC_ADDR_WIDTH'(8 + n);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    vec_idx_d     = vec_idx_q;
    cause_d       = cause_q;
    epc_d         = epc_q;
    redirect_pc_d = redirect_pc_q;
    redirect_d    = redirect_q;
    in_handler_d  = in_handler_q;

    case (state_q)
      S_IDLE: begin
        if (i_exc_valid) begin
          vec_idx_d = VEC_ADDR_WIDTH'(i_exc_code);
          cause_d   = VEC_ADDR_WIDTH'(i_exc_code);
          epc_d     = i_epc;
          state_d   = S_LOOKUP;
        end else if (irq_any) begin
          vec_idx_d = irq_idx;
          cause_d   = irq_idx;
          epc_d     = i_epc;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        redirect_pc_d = i_vec_data;
        redirect_d    = 1'b1;
        state_d       = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (i_redirect_ack) begin
          redirect_d   = 1'b0;
          in_handler_d = 1'b1;
          state_d      = S_HANDLER;
        end
      end
      S_HANDLER: begin
        // Double fault keeps the original return address so ERET still unwinds to the first fault.
        if (i_exc_valid) begin
          vec_idx_d = VEC_ADDR_WIDTH'(15);
          cause_d   = VEC_ADDR_WIDTH'(15);
          state_d   = S_LOOKUP;
        end else if (i_eret) begin
          redirect_pc_d = epc_q;
          redirect_d    = 1'b1;
          state_d       = S_RETURN;
        end
      end
      S_RETURN: begin
        if (i_redirect_ack) begin
          redirect_d   = 1'b0;
          in_handler_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      vec_idx_q     <= '0;
      cause_q       <= '0;
      epc_q         <= '0;
      redirect_pc_q <= '0;
      redirect_q    <= 1'b0;
      in_handler_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      vec_idx_q     <= vec_idx_d;
      cause_q       <= cause_d;
      epc_q         <= epc_d;
      redirect_pc_q <= redirect_pc_d;
      redirect_q    <= redirect_d;
      in_handler_q  <= in_handler_d;
    end
  end

  assign o_vec_idx     = vec_idx_q;
  assign o_cause       = cause_q;
  assign o_epc         = epc_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_redirect    = redirect_q;
  assign o_in_handler  = in_handler_q;

endmodule

// File: tb/tb_exc_vector_ctrl.sv
// Bench for exc_vector_ctrl: directed table, corner sequences and randomized episodes checked against a rule-level model.
module tb_exc_vector_ctrl;

`ifdef EXC_IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [6:0]  i_irq;
  logic        i_exc_valid;
  logic [2:0]  i_exc_code;
  logic [31:0] i_epc;
  logic        i_eret;
  logic        i_redirect_ack;
  logic [3:0]  o_vec_idx;
  logic [31:0] i_vec_data;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_epc;
  logic [3:0]  o_cause;
  logic        o_in_handler;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_idx;

  exc_vector_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_exc_valid(i_exc_valid),
    .i_exc_code(i_exc_code), .i_epc(i_epc), .i_eret(i_eret), .i_redirect_ack(i_redirect_ack),
    .o_vec_idx(o_vec_idx), .i_vec_data(i_vec_data), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_epc(o_epc), .o_cause(o_cause), .o_in_handler(o_in_handler)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rom(input logic [3:0] idx);
    return 32'h8000_0000 + 32'(idx) * 32'h80;
  endfunction

  assign i_vec_data = rom(o_vec_idx);

  // Exception beats irqs; lowest irq line wins; irq n maps to 8+n.
  function automatic logic [3:0] ref_idx(input logic exc, input logic [2:0] code, input logic [6:0] irq);
    if (exc) return {1'b0, code};
    for (int n = 0; n < 7; n++) if (irq[n]) return 4'(8 + n);
    return 4'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic episode(input logic exc, input logic [2:0] code, input logic [6:0] irq,
                         input logic [31:0] epc, input logic [3:0] exp, input int ack_dly,
                         input int hcyc, input logic dbl, input int ret_dly, input logic keep);
    logic [3:0] prev, cur;
    int lat;
    prev = last_idx;
    lat  = exc ? 1 : IRQ_LAT;
    i_exc_valid = exc; i_exc_code = code; i_irq = irq; i_epc = epc;
    for (int k = 1; k <= lat; k++) begin
      step();
      i_exc_valid = 1'b0;
      if (k < lat) chk("idx_before_latency", 32'(o_vec_idx), 32'(prev));
    end
    i_epc = $urandom;
    chk("vec_idx", 32'(o_vec_idx), 32'(exp));
    chk("cause", 32'(o_cause), 32'(exp));
    chk("epc_latch", o_epc, epc);
    chk("redirect_in_lookup", 32'(o_redirect), 32'd0);
    chk("in_handler_lookup", 32'(o_in_handler), 32'd0);
    step();
    chk("redirect_on", 32'(o_redirect), 32'd1);
    chk("redirect_pc", o_redirect_pc, rom(exp));
    for (int k = 0; k < ack_dly; k++) begin
      i_exc_valid = 1'($urandom % 2); i_exc_code = 3'($urandom);
      step();
      chk("redirect_hold", 32'(o_redirect), 32'd1);
      chk("pc_hold", o_redirect_pc, rom(exp));
      chk("idx_hold", 32'(o_vec_idx), 32'(exp));
    end
    i_exc_valid = 1'b0; i_redirect_ack = 1'b1;
    step();
    i_redirect_ack = 1'b0;
    chk("redirect_off", 32'(o_redirect), 32'd0);
    chk("in_handler_on", 32'(o_in_handler), 32'd1);
    for (int k = 0; k < hcyc; k++) begin
      i_redirect_ack = 1'($urandom % 2);
      step();
      chk("handler_quiet", 32'(o_redirect), 32'd0);
      chk("handler_flag", 32'(o_in_handler), 32'd1);
      chk("irq_masked", 32'(o_vec_idx), 32'(exp));
    end
    i_redirect_ack = 1'b0;
    cur = exp;
    if (dbl) begin
      i_exc_valid = 1'b1; i_exc_code = 3'($urandom); i_eret = 1'($urandom % 2); i_epc = $urandom;
      step();
      i_exc_valid = 1'b0; i_eret = 1'b0;
      chk("dbl_idx", 32'(o_vec_idx), 32'd15);
      chk("dbl_cause", 32'(o_cause), 32'd15);
      chk("dbl_epc_kept", o_epc, epc);
      step();
      chk("dbl_redirect", 32'(o_redirect), 32'd1);
      chk("dbl_pc", o_redirect_pc, rom(4'd15));
      i_redirect_ack = 1'b1;
      step();
      i_redirect_ack = 1'b0;
      chk("dbl_ack", 32'(o_redirect), 32'd0);
      chk("dbl_in_handler", 32'(o_in_handler), 32'd1);
      cur = 4'd15;
    end
    if (!keep) i_irq = '0;
    i_eret = 1'b1;
    step();
    i_eret = 1'b0;
    chk("ret_redirect", 32'(o_redirect), 32'd1);
    chk("ret_pc", o_redirect_pc, epc);
    chk("ret_in_handler", 32'(o_in_handler), 32'd1);
    for (int k = 0; k < ret_dly; k++) begin
      step();
      chk("ret_hold", 32'(o_redirect), 32'd1);
      chk("ret_pc_hold", o_redirect_pc, epc);
    end
    i_redirect_ack = 1'b1;
    step();
    i_redirect_ack = 1'b0;
    chk("ret_done", 32'(o_redirect), 32'd0);
    chk("handler_exit", 32'(o_in_handler), 32'd0);
    last_idx = cur;
    if (!keep) begin
      i_eret = 1'b1; i_redirect_ack = 1'b1;
      step();
      i_eret = 1'b0; i_redirect_ack = 1'b0;
      chk("idle_eret_ignored", 32'(o_redirect), 32'd0);
      chk("idle_idx_hold", 32'(o_vec_idx), 32'(cur));
      chk("idle_handler", 32'(o_in_handler), 32'd0);
    end
  endtask

  typedef struct {
    logic        exc;
    logic [2:0]  code;
    logic [6:0]  irq;
    logic [31:0] epc;
    logic [3:0]  exp;
    int          ack_dly;
    int          hcyc;
    logic        dbl;
    int          ret_dly;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    logic        r_exc;
    logic [2:0]  r_code;
    logic [6:0]  r_irq;

    tbl[0] = '{1'b1, 3'd3, 7'b0000000, 32'h0000_0100, 4'd3,  0, 1, 1'b0, 0};
    tbl[1] = '{1'b0, 3'd0, 7'b0010100, 32'h0000_0140, 4'd10, 2, 4, 1'b0, 1};
    tbl[2] = '{1'b1, 3'd0, 7'b1000000, 32'h0000_0200, 4'd0,  1, 2, 1'b1, 0};
    tbl[3] = '{1'b1, 3'd7, 7'b0000000, 32'hFFFF_FFFC, 4'd7,  5, 0, 1'b0, 2};
    tbl[4] = '{1'b0, 3'd5, 7'b1000000, 32'h1234_5678, 4'd14, 0, 3, 1'b1, 0};
    tbl[5] = '{1'b0, 3'd0, 7'b1111111, 32'h0000_0A00, 4'd8,  3, 2, 1'b0, 3};

    i_rst_n = 1'b0; i_irq = '0; i_exc_valid = 1'b0; i_exc_code = '0;
    i_epc = '0; i_eret = 1'b0; i_redirect_ack = 1'b0;
    last_idx = '0;
    #12;
    chk("rst_vec_idx", 32'(o_vec_idx), 32'd0);
    chk("rst_cause", 32'(o_cause), 32'd0);
    chk("rst_epc", o_epc, 32'd0);
    chk("rst_redirect", 32'(o_redirect), 32'd0);
    chk("rst_redirect_pc", o_redirect_pc, 32'd0);
    chk("rst_in_handler", 32'(o_in_handler), 32'd0);
    step();
    i_rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      episode(tbl[i].exc, tbl[i].code, tbl[i].irq, tbl[i].epc, tbl[i].exp,
              tbl[i].ack_dly, tbl[i].hcyc, tbl[i].dbl, tbl[i].ret_dly, 1'b0);

    // Exception and irq 0 together: irq stays pending and is taken right after the return.
    episode(1'b1, 3'd1, 7'b0000001, 32'h0000_0400, 4'd1, 1, 2, 1'b0, 0, 1'b1);
    i_epc = 32'h0000_0300;
    step();
    chk("pend_idx", 32'(o_vec_idx), 32'd8);
    chk("pend_cause", 32'(o_cause), 32'd8);
    chk("pend_epc", o_epc, 32'h0000_0300);
    step();
    chk("pend_redirect", 32'(o_redirect), 32'd1);
    chk("pend_pc", o_redirect_pc, rom(4'd8));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("noack_redirect", 32'(o_redirect), 32'd1);
      chk("noack_pc", o_redirect_pc, rom(4'd8));
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_redirect", 32'(o_redirect), 32'd0);
    chk("arst_pc", o_redirect_pc, 32'd0);
    chk("arst_epc", o_epc, 32'd0);
    chk("arst_cause", 32'(o_cause), 32'd0);
    chk("arst_vec_idx", 32'(o_vec_idx), 32'd0);
    chk("arst_in_handler", 32'(o_in_handler), 32'd0);
    i_irq = '0;
    step();
    i_rst_n = 1'b1;
    last_idx = '0;

    for (int i = 0; i < 40; i++) begin
      r_exc  = 1'($urandom % 2);
      r_code = 3'($urandom);
      r_irq  = 7'($urandom);
      if (!r_exc && r_irq == 7'd0) r_irq = 7'd1 << $urandom_range(0, 6);
      episode(r_exc, r_code, r_irq, $urandom, ref_idx(r_exc, r_code, r_irq),
              $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom % 2),
              $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_vector_ctrl.md
EXC_VECTOR_CTRL -- requirements
Module: exc_vector_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of PC, EPC and vector data.
REQ-002 Parameter VEC_ADDR_WIDTH, default 4, width of the vector table index.
REQ-003 Parameter IRQ_LINES, default 7, number of interrupt inputs; SHALL be at most 7.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_irq  in  IRQ_LINES  level-sensitive interrupt requests.
REQ-007 i_exc_valid  in  1  synchronous exception from the pipeline, one-cycle pulse.
REQ-008 i_exc_code  in  3  exception code 0..7.
REQ-009 i_epc  in  DATA_WIDTH  PC of the faulting or interrupted instruction.
REQ-010 i_eret  in  1  return-from-exception pulse from the pipeline.
REQ-011 i_redirect_ack  in  1  pipeline accepted the redirect.
REQ-012 o_vec_idx  out  VEC_ADDR_WIDTH  index to the vector table ROM.
REQ-013 i_vec_data  in  DATA_WIDTH  handler address returned combinationally by the ROM.
REQ-014 o_redirect  out  1  redirect request to the fetch stage.
REQ-015 o_redirect_pc  out  DATA_WIDTH  target PC of the redirect.
REQ-016 o_epc  out  DATA_WIDTH  saved return address.
REQ-017 o_cause  out  VEC_ADDR_WIDTH  index of the last taken event.
REQ-018 o_in_handler  out  1  a handler is currently executing.

Function
REQ-019 FSM states IDLE, LOOKUP, REDIRECT, HANDLER, RETURN.
REQ-020 Index map: exception code c -> c; irq line n -> 8+n; double fault -> 15.
REQ-021 Priority: exception over any irq; among irqs, the lowest line number wins.
REQ-022 IDLE: on an event at edge N, latch the index into o_vec_idx and o_cause, latch i_epc into o_epc, and go to LOOKUP.
REQ-023 LOOKUP: capture i_vec_data into o_redirect_pc at edge N+1 and go to REDIRECT; o_redirect SHALL be high from edge N+1 (cycle N+2).
REQ-024 REDIRECT: hold o_redirect and o_redirect_pc stable until i_redirect_ack is sampled high, then go to HANDLER and deassert o_redirect.
REQ-025 HANDLER: o_in_handler=1 and irqs are masked; i_eret loads o_epc into o_redirect_pc and goes to RETURN.
REQ-026 RETURN: assert o_redirect until acked, then go to IDLE with o_in_handler=0.
REQ-027 i_exc_valid in HANDLER: double fault, index 15, via LOOKUP; o_epc SHALL NOT be overwritten.
REQ-028 i_exc_valid and i_eret in the same HANDLER cycle: the exception wins.
REQ-029 i_exc_valid and an irq in the same IDLE cycle: the exception is taken; the irq stays pending and is taken after return.
REQ-030 i_eret in IDLE, and any event in LOOKUP, REDIRECT or RETURN, SHALL be ignored.
REQ-031 i_redirect_ack while o_redirect=0 SHALL be ignored.
REQ-032 o_vec_idx SHALL hold its last value outside LOOKUP.

Reset
REQ-033 i_rst_n low SHALL immediately force IDLE and zero all outputs and internal registers, including mid-redirect (o_redirect drops asynchronously).
REQ-034 Reset release SHALL take effect on the first rising edge with i_rst_n high.

Configuration
REQ-035 Macro EXC_IRQ_SYNC_EN: when defined, i_irq passes through a two-flop synchronizer, adding 2 cycles of irq latency; the synchronizer is reset to 0.
REQ-036 Without EXC_IRQ_SYNC_EN, i_irq is sampled directly; exception timing SHALL be identical in both builds.

Verification
REQ-037 i_exc_valid=1, code 3, i_epc=0x100 at cycle 0, ROM[3]=0x80000180 -> o_vec_idx=3 at cycle 1, o_redirect=1 with PC 0x80000180 at cycle 2, o_epc=0x100.
REQ-038 i_irq=7'b0010100 in IDLE -> o_cause=10, o_vec_idx=10; after ack o_in_handler=1; irq held high is not retaken until ERET.
REQ-039 Exception code 1 and irq line 0 in the same cycle -> index 1 taken; after ERET and ack, index 8 taken.
REQ-040 Exception in HANDLER with o_epc=0x200 -> index 15 lookup, o_epc remains 0x200.
REQ-041 Ack withheld 5 cycles -> o_redirect and PC stable; i_rst_n pulsed low mid-REDIRECT -> all outputs 0 immediately, state IDLE.
REQ-042 Build with EXC_IRQ_SYNC_EN -> irq-to-o_vec_idx latency 3 cycles versus 1 without.
